// File: rtl/wisc_pkg.sv
// Shared ISA constants: ALU opcodes, branch condition codes, flag bit indices,
// and the per-opcode flag write mask.
package wisc_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_XOR     = 3'b010,
        OP_RED     = 3'b011,
        OP_SLL     = 3'b100,
        OP_SRA     = 3'b101,
        OP_ROR     = 3'b110,
        OP_PADDSUB = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_OV = 3'b110,
        CC_UN = 3'b111
    } cc_e;

    localparam int unsigned FZ = 2;
    localparam int unsigned FV = 1;
    localparam int unsigned FN = 0;

    // Flag bits an opcode defines; bits outside the mask are don't-care from the ALU.
    function automatic logic [2:0] flag_mask(input logic [2:0] op);
        logic [2:0] m;
        m = '0;
        case (op)
            OP_ADD, OP_SUB:          m = '1;
            OP_XOR, OP_SLL,
            OP_SRA, OP_ROR:          m = 3'b100;
            default:                 m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_unit_cond_eval.sv
// Branch condition evaluator: decodes a 3-bit condition code against Z/V/N.
module cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] f,
    output logic       cond
);

    // Pure decode of the condition code against the supplied flags
    always_comb begin
        cond = 1'b0;
        case (ccc)
            CC_NE:   cond = ~f[FZ];
            CC_EQ:   cond =  f[FZ];
            CC_GT:   cond = ~f[FZ] & ~f[FN];
            CC_LT:   cond =  f[FN];
            CC_GE:   cond =  f[FZ] | ~f[FN];
            CC_LE:   cond =  f[FN] | f[FZ];
            CC_OV:   cond =  f[FV];
            default: cond = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag register with per-opcode selective update and branch
// resolution, with optional same-cycle forwarding of the flag write.
module flag_unit
    import wisc_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic       ex_alu_op,
    input  logic [2:0] ex_opcode,
    input  logic [2:0] ex_flags,
    input  logic       stall,
    input  logic       flush,
    input  logic       br_valid,
    input  logic [2:0] br_ccc,
    output logic [2:0] flags_q,
    output logic       br_taken,
    output logic       br_hazard
);

    logic       upd;
    logic [2:0] mask;
    logic [2:0] nxt;
    logic [2:0] f;
    logic       cond;

    // Qualify the write and merge only the defined flag bits; the ternary keeps
    // undefined ALU bits from propagating when their mask bit is clear
    always_comb begin
        upd  = ex_valid & ex_alu_op & ~stall & ~flush;
        mask = flag_mask(ex_opcode);
        nxt  = flags_q;
        for (int unsigned i = 0; i < 3; i++) begin
            nxt[i] = (upd & mask[i]) ? ex_flags[i] : flags_q[i];
        end
    end

    // Architectural flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= nxt;
    end

    // Pick the evaluation source and stall decode while a write is in flight
    // when forwarding is disabled
    always_comb begin
        if (BYPASS) begin
            f         = nxt;
            br_hazard = 1'b0;
        end else begin
            f         = flags_q;
            br_hazard = br_valid & upd & (mask != 3'b000);
        end
    end

    cond_eval u_cond_eval (
        .ccc  (br_ccc),
        .f    (f),
        .cond (cond)
    );

    // Final branch decision, suppressed while decode must stall
    always_comb begin
        br_taken = br_valid & cond & ~br_hazard;
    end

endmodule

// File: doc/flag_unit.md
# flag_unit

Condition-flag register and branch-condition evaluator sitting directly downstream of the EX-stage ALU. Captures the ALU's Z/V/N outputs with per-opcode selective update, so only the bits an instruction defines are written. Resolves the 3-bit branch condition code for the branch in decode, optionally bypassing the flag value being written this cycle. Produces a stall request when the branch cannot be resolved yet.

## Interface
Parameters:
- BYPASS, 1, 1 = branch evaluation sees this cycle's qualifying flag write; 0 = registered flags only, with hazard stall.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- ex_valid  input  1  a real instruction occupies EX this cycle.
- ex_alu_op  input  1  EX instruction is an ALU-class instruction; 0 for LW/SW/LLB/LHB/branch/PCS/HLT, even when the ALU computes an address.
- ex_opcode  input  3  ALU opcode driven into the ALU.
- ex_flags  input  3  ALU Flags output; [2]=Z, [1]=V, [0]=N.
- stall  input  1  pipeline hold; EX does not advance.
- flush  input  1  kill the EX instruction.
- br_valid  input  1  a conditional branch is in decode.
- br_ccc  input  3  branch condition code.
- flags_q  output  3  architectural flag register, same bit order as ex_flags.
- br_taken  output  1  combinational branch decision.
- br_hazard  output  1  decode must stall; the branch depends on an unresolved flag write.

## Operation
- Update qualifier: upd = ex_valid & ex_alu_op & ~stall & ~flush.
- Per-bit write mask by ex_opcode:
  - 000 ADD, 001 SUB: Z, V, N.
  - 010 XOR, 100 SLL, 101 SRA, 110 ROR: Z only.
  - 011 RED, 111 PADDSUB: none.
- ALU flag bits outside the mask are undefined, possibly X; they must never reach flags_q or br_taken.
- Next-flag merge: per bit, nxt[i] = (upd & mask[i]) ? ex_flags[i] : flags_q[i].
- Evaluation source f:
  - BYPASS=1: f = nxt.
  - BYPASS=0: f = flags_q.
- Condition decode on f:
  - 000 NE: ~Z.
  - 001 EQ: Z.
  - 010 GT: ~Z & ~N.
  - 011 LT: N.
  - 100 GE: Z | (~Z & ~N).
  - 101 LE: N | Z.
  - 110 OV: V.
  - 111 UN: 1.
- br_taken = br_valid & cond(f) & ~br_hazard.
- br_hazard:
  - BYPASS=0: br_valid & upd & (mask != 0). Covers the case where a write is in flight and f is stale.
  - BYPASS=1: tied 0.

## Timing
- Reset: flags_q = 3'b000 immediately on rst_n low, held while low. br_taken and br_hazard are combinational and therefore 0 whenever br_valid=0.
- flags_q <= nxt at each posedge clk while rst_n is high. One-cycle write latency.
- Simultaneous stall and flush: no update; flush needs no extra handling.
- An ALU-class instruction with an empty mask (RED/PADDSUB) never raises br_hazard.
- Back-to-back flag writers: each qualifying cycle writes independently; the last write wins per bit.
- Stall held for N cycles: flags_q constant throughout. br_taken may be re-evaluated each cycle from the unchanged source.
- Reset asserted mid-stream: flags clear asynchronously; the first post-reset write behaves as a normal cycle.

## Structure
- Shared package (wisc_pkg):
  - ALU opcode constants OP_ADD..OP_PADDSUB.
  - CCC constants CC_NE..CC_UN.
  - Flag index localparams FZ=2, FV=1, FN=0.
- Sub-module cond_eval: pure combinational, inputs ccc[2:0] and f[2:0], output cond. Reused later by the branch-predict check.
- Remainder, in this block: the mask decode, the merge, and the 3-bit register.

## Test plan
- Reset then ADD: rst_n low mid-cycle, flags_q=000 asynchronously. Then ADD with ex_flags=3'b101 and upd=1 gives flags_q=101 next edge.
- Mask: after flags_q=111, XOR with ex_flags=3'b0X0 gives flags_q=011 with no X. RED with ex_flags=XXX leaves flags_q unchanged.
- Qualifier: SUB with ex_flags=010 under each of stall=1, flush=1, ex_alu_op=0 (LW) and ex_valid=0 leaves flags_q unchanged.
- Full sweep: all 8 ccc × all 8 flag patterns with br_valid=1 and no write in flight; br_taken matches the decode list (e.g. GT with f=000 gives 1, GT with f=001 gives 0).
- BYPASS=1 forwarding: flags_q=000; same cycle, SUB with ex_flags=100 and branch EQ gives br_taken=1 and br_hazard=0.
- BYPASS=0 hazard:
  - Same stimulus gives br_hazard=1 and br_taken=0.
  - Next cycle, upd=0: br_hazard=0 and br_taken=1.
  - PADDSUB in EX instead gives br_hazard=0.
